// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier, restoring divider,
// fast path for divide-by-zero and signed overflow, flushable mid-operation.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide bit per cycle, counter runs N..1
// FIXUP | sign correction, half select, word sign-extension, result register load
// DONE  | done pulse; a new start here is accepted without an idle bubble
module muldiv_unit #(
    parameter int XLEN     = 64,
    parameter bit WORD_OPS = 1'b1
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic            isWord,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rdIn,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd
);

    localparam bit WORD_EN = WORD_OPS && (XLEN == 64);
    localparam int CW      = $clog2(XLEN + 1);
    localparam int WSH     = XLEN - 32;
    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = ~{{(XLEN-31){1'b0}}, {31{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic                word_q, word_d;
    logic                neg_q, neg_d;
    logic [4:0]          tag_q, tag_d;
    logic [XLEN-1:0]     x_q, x_d;
    logic [2*XLEN-1:0]   y_q, y_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_q, rd_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    logic            word_in, is_div_in, a_signed, b_signed;
    logic            a_neg, b_neg, neg_in, div_zero, div_ovf, fast_in;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;

    always_comb begin
        word_in   = WORD_EN && isWord;
        is_div_in = funct3[2];
        a_signed  = is_div_in ? !funct3[0] : (funct3 != 3'd3);
        b_signed  = is_div_in ? !funct3[0] : (funct3[1] == 1'b0);
        a_ext     = a;
        b_ext     = b;
        if (word_in) begin
            a_ext = a_signed ? sext32(a[31:0]) : zext32(a[31:0]);
            b_ext = b_signed ? sext32(b[31:0]) : zext32(b[31:0]);
        end
        a_neg    = a_signed && a_ext[XLEN-1];
        b_neg    = b_signed && b_ext[XLEN-1];
        mag_a    = a_neg ? -a_ext : a_ext;
        mag_b    = b_neg ? -b_ext : b_ext;
        // Remainder takes the dividend's sign; everything else the XOR of both.
        neg_in   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = (b_ext == '0);
        div_ovf  = a_signed && (a_ext == (word_in ? MIN_W : MIN_S)) && (b_ext == '1);
        fast_in  = is_div_in && (div_zero || div_ovf);
    end

    logic [XLEN:0]     rem_sh, diff;
    logic              q_bit;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_sel, div_val, div_sel, fix_val;

    always_comb begin
        rem_sh  = {acc_q[XLEN-1:0], x_q[XLEN-1]};
        diff    = rem_sh - {1'b0, y_q[XLEN-1:0]};
        q_bit   = !diff[XLEN];
        prod    = neg_q ? -acc_q : acc_q;
        if (f3_q[1:0] == 2'b00)
            mul_sel = prod[XLEN-1:0];
        else if (word_q)
            mul_sel = prod[32 +: XLEN];
        else
            mul_sel = prod[XLEN +: XLEN];
        div_val = f3_q[1] ? acc_q[XLEN-1:0] : x_q;
        div_sel = neg_q ? -div_val : div_val;
        fix_val = f3_q[2] ? div_sel : mul_sel;
        if (word_q)
            fix_val = sext32(fix_val[31:0]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        word_d   = word_q;
        neg_d    = neg_q;
        tag_d    = tag_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_d     = rd_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (start) begin
                        f3_d   = funct3;
                        word_d = word_in;
                        tag_d  = rdIn;
                        cnt_d  = word_in ? CW'(32) : CW'(XLEN);
                        neg_d  = neg_in;
                        acc_d  = '0;
                        y_d    = {{XLEN{1'b0}}, is_div_in ? mag_b : mag_a};
                        x_d    = is_div_in ? (word_in ? (mag_a << WSH) : mag_a) : mag_b;
                        // Fast path preloads quotient/remainder so FIXUP needs no special case.
                        if (is_div_in && div_zero) begin
                            neg_d = 1'b0;
                            x_d   = '1;
                            acc_d = {{XLEN{1'b0}}, a_ext};
                        end else if (is_div_in && div_ovf) begin
                            neg_d = 1'b0;
                            x_d   = a_ext;
                        end
                        state_d = fast_in ? S_FIXUP : S_CALC;
                    end
                end
                S_CALC: begin
                    if (f3_q[2]) begin
                        acc_d = {{XLEN{1'b0}}, q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]};
                        x_d   = {x_q[XLEN-2:0], q_bit};
                    end else begin
                        acc_d = acc_q + (x_q[0] ? y_q : '0);
                        y_d   = y_q << 1;
                        x_d   = x_q >> 1;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_d = S_FIXUP;
                end
                S_FIXUP: begin
                    result_d = fix_val;
                    rd_d     = tag_q;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            tag_q    <= tag_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=64): directed spec cases plus
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetN, start, flush, isWord;
    logic [2:0]  funct3;
    logic [63:0] a, b;
    logic [4:0]  rdIn;
    logic        busy, done;
    logic [63:0] result;
    logic [4:0]  rd;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64), .WORD_OPS(1'b1)) dut (
        .clk(clk), .resetN(resetN), .start(start), .flush(flush),
        .funct3(funct3), .isWord(isWord), .a(a), .b(b), .rdIn(rdIn),
        .busy(busy), .done(done), .result(result), .rd(rd)
    );

    function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                          input logic [63:0] av, input logic [63:0] bv);
        logic signed [31:0]  sa32, sb32;
        logic signed [63:0]  sa64, sb64;
        logic signed [127:0] wa, wb;
        logic [127:0]        p;
        logic [31:0]         r32;
        logic [63:0]         r64;
        sa32 = av[31:0]; sb32 = bv[31:0];
        sa64 = av;       sb64 = bv;
        r32 = '0; r64 = '0; p = '0;
        if (w) begin
            case (f3)
                3'd0: r32 = av[31:0] * bv[31:0];
                3'd4: if (sb32 == 0) r32 = '1;
                      else if (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) r32 = sa32;
                      else r32 = sa32 / sb32;
                3'd5: if (bv[31:0] == 0) r32 = '1; else r32 = av[31:0] / bv[31:0];
                3'd6: if (sb32 == 0) r32 = sa32;
                      else if (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) r32 = '0;
                      else r32 = sa32 % sb32;
                3'd7: if (bv[31:0] == 0) r32 = av[31:0]; else r32 = av[31:0] % bv[31:0];
                default: r32 = '0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (f3)
            3'd0: r64 = av * bv;
            3'd1: begin wa = sa64; wb = sb64; p = wa * wb; r64 = p[127:64]; end
            3'd2: begin wa = sa64; wb = {64'd0, bv}; p = wa * wb; r64 = p[127:64]; end
            3'd3: begin p = {64'd0, av} * {64'd0, bv}; r64 = p[127:64]; end
            3'd4: if (sb64 == 0) r64 = '1;
                  else if (sa64 == 64'sh8000_0000_0000_0000 && sb64 == -64'sd1) r64 = sa64;
                  else r64 = sa64 / sb64;
            3'd5: if (bv == 0) r64 = '1; else r64 = av / bv;
            3'd6: if (sb64 == 0) r64 = sa64;
                  else if (sa64 == 64'sh8000_0000_0000_0000 && sb64 == -64'sd1) r64 = '0;
                  else r64 = sa64 % sb64;
            default: if (bv == 0) r64 = av; else r64 = av % bv;
        endcase
        return r64;
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic w,
                                       input logic [63:0] av, input logic [63:0] bv);
        logic bz, ov;
        bz = w ? (bv[31:0] == 32'd0) : (bv == 64'd0);
        ov = !f3[0] && (w ? (av[31:0] == 32'h8000_0000 && bv[31:0] == 32'hFFFF_FFFF)
                          : (av == 64'h8000_0000_0000_0000 && bv == '1));
        if (f3[2] && (bz || ov)) return 2;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0, 1, 2: return {$urandom(), $urandom()};
            3:       return 64'd0;
            4:       return '1;
            5:       return 64'h8000_0000_0000_0000;
            6:       return {$urandom(), 32'h8000_0000};
            default: return 64'($urandom_range(0, 20));
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] av,
                          input logic [63:0] bv, input logic [4:0] r,
                          input logic [63:0] exp_res, input string name);
        int lat, el;
        bit got, busy_ok;
        el = exp_latency(f3, w, av, bv);
        funct3 = f3; isWord = w; a = av; b = bv; rdIn = r; start = 1'b1;
        lat = 0; got = 0; busy_ok = 1;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (done === 1'b1) got = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s timeout: no done after %0d cycles, required at %0d", name, lat, el);
        end
        n_tests++;
        if (lat != el) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, el);
        end
        n_tests++;
        if (result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h required %h (f3=%0d w=%0b a=%h b=%h)",
                     name, result, exp_res, f3, w, av, bv);
        end
        n_tests++;
        if (rd !== r) begin
            n_fail++;
            $display("FAIL %s rd: got %0d required %0d", name, rd, r);
        end
        n_tests++;
        if (!busy_ok || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy: got busy_ok=%0b busy_at_done=%b required 1/0", name, busy_ok, busy);
        end
        last_res = exp_res;
        last_rd  = r;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: got done=%b busy=%b required 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; start = 1'b0; flush = 1'b0; isWord = 1'b0;
        funct3 = '0; a = '0; b = '0; rdIn = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset: got busy=%b done=%b result=%h rd=%0d required all 0", busy, done, result, rd);
        end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(3'd0, 1'b0, 64'd7, -64'sd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, "mul");
        idle_check("mul");
        run_op(3'd3, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu");
        idle_check("mulhu");
        run_op(3'd1, 1'b0, '1, '1, 5'd3, 64'd0, "mulh");
        idle_check("mulh");
        run_op(3'd2, 1'b0, '1, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
        idle_check("mulhsu");
        run_op(3'd4, 1'b0, -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, "div");
        idle_check("div");
        run_op(3'd6, 1'b0, -64'sd7, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, "rem");
        idle_check("rem");
        run_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 5'd7, 64'hFFFF_FFFF_8000_0000, "divw");
        idle_check("divw");
        run_op(3'd5, 1'b0, 64'h1234, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, "divu_zero");
        idle_check("divu_zero");
        run_op(3'd6, 1'b0, 64'd5, 64'd0, 5'd9, 64'd5, "rem_zero");
        idle_check("rem_zero");
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd10, 64'h8000_0000_0000_0000, "div_ovf");
        idle_check("div_ovf");
        run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 64'd0, "rem_ovf");
        idle_check("rem_ovf");
        run_op(3'd7, 1'b1, 64'h0000_0000_9000_0001, 64'hFFFF_FFFF_0000_0000, 5'd12,
               64'hFFFF_FFFF_9000_0001, "remuw_zero");
        idle_check("remuw_zero");
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 1'b0, 64'd123456789, 64'd987654321, 5'd13, 64'd121932631112635269, "b2b_first");
        run_op(3'd0, 1'b0, -64'sd2, 64'd5, 5'd14, 64'hFFFF_FFFF_FFFF_FFF6, "b2b_second");
        idle_check("b2b");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic        w;
        logic [63:0] av, bv;
        logic [4:0]  r;
        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom_range(0, 7));
            w  = ((f3 == 3'd0) || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            av = pick();
            bv = pick();
            r  = 5'($urandom_range(1, 31));
            run_op(f3, w, av, bv, r, model(f3, w, av, bv), "rand");
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end
    endtask

    task automatic test_flush();
        bit seen;
        funct3 = 3'd4; isWord = 1'b0; a = 64'd1000; b = 64'd7; rdIn = 5'd20; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush state: got busy=%b done=%b required 0/0", busy, done);
        end
        n_tests++;
        if (result !== last_res || rd !== last_rd) begin
            n_fail++;
            $display("FAIL flush hold: got result=%h rd=%0d required %h/%0d", result, rd, last_res, last_rd);
        end
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush no_done: got activity after flush, required none");
        end
        // flush wins over start presented in the same cycle
        funct3 = 3'd0; a = 64'd3; b = 64'd3; rdIn = 5'd21; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush priority: got busy=%b required 0", busy);
        end
        idle_check("flush_priority");
    endtask

    task automatic test_reset_mid();
        funct3 = 3'd0; isWord = 1'b0; a = 64'd99; b = 64'd77; rdIn = 5'd22; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        resetN = 1'b0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h rd=%0d required all 0", busy, done, result, rd);
        end
        resetN = 1'b1;
        last_res = '0;
        last_rd  = '0;
        idle_check("reset_mid");
        run_op(3'd5, 1'b0, 64'd100, 64'd7, 5'd23, 64'd14, "after_reset");
        idle_check("after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
